// File: rtl/cart_bank_mapper_pkg.sv
// Shared cartridge mapper types: mapper encoding, lookup entry and the
// per-mapper reset bank vector / window-size table.
package cart_bank_mapper_pkg;

    typedef enum logic [4:0] {
        MAPPER_NONE       = 5'd0,
        MAPPER_ASCII8     = 5'd1,
        MAPPER_ASCII16    = 5'd2,
        MAPPER_KONAMI     = 5'd3,
        MAPPER_KONAMI_SCC = 5'd4,
        MAPPER_LINEAR     = 5'd5
    } mapper_typ_t;

    typedef struct packed {
        logic [26:0] addr;
        logic [15:0] size;
    } lookup_ram_t;

    // reset_banks[i] is the value loaded into bank register r<i>
    typedef struct packed {
        logic           win16k;
        logic [3:0][7:0] reset_banks;
    } mapper_cfg_t;

    localparam mapper_cfg_t CFG_NONE       = '{win16k: 1'b0, reset_banks: 32'h0000_0000};
    localparam mapper_cfg_t CFG_LINEAR     = '{win16k: 1'b0, reset_banks: 32'h0000_0000};
    localparam mapper_cfg_t CFG_ASCII8     = '{win16k: 1'b0, reset_banks: 32'h0000_0000};
    localparam mapper_cfg_t CFG_ASCII16    = '{win16k: 1'b1, reset_banks: 32'h0000_0000};
    localparam mapper_cfg_t CFG_KONAMI     = '{win16k: 1'b0, reset_banks: 32'h0302_0100};
    localparam mapper_cfg_t CFG_KONAMI_SCC = '{win16k: 1'b0, reset_banks: 32'h0302_0100};
    localparam mapper_cfg_t CFG_UNMAPPED   = '{win16k: 1'b0, reset_banks: 32'h0000_0000};

    function automatic mapper_cfg_t mapper_cfg(logic [4:0] typ);
        mapper_cfg_t c;
        case (typ)
            MAPPER_NONE:       c = CFG_NONE;
            MAPPER_LINEAR:     c = CFG_LINEAR;
            MAPPER_ASCII8:     c = CFG_ASCII8;
            MAPPER_ASCII16:    c = CFG_ASCII16;
            MAPPER_KONAMI:     c = CFG_KONAMI;
            MAPPER_KONAMI_SCC: c = CFG_KONAMI_SCC;
            default:           c = CFG_UNMAPPED;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/cart_bank_mapper_page_mask.sv
// Image size (8 KB units) to page mask: (next power of two >= size) - 1.
// Also used by the SRAM path, so kept free of mapper knowledge.
module cart_page_mask (
    input  logic [15:0] size,
    output logic [15:0] pmask
);

    logic [15:0] size_m1;

    // Smear the leading one of size-1 downward; exact powers of two stay exact.
    always_comb begin
        size_m1   = size - 16'd1;
        pmask     = '0;
        pmask[15] = size_m1[15];
        for (int i = 14; i >= 0; i--) begin
            pmask[i] = pmask[i+1] | size_m1[i];
        end
    end

endmodule

// File: rtl/cart_bank_mapper.sv
// Per-slot ROM bank mapper: bank registers plus CPU-to-SDRAM address
// translation. Optional SCC register window under CART_BANK_MAPPER_SCC_EN.
module cart_bank_mapper
    import cart_bank_mapper_pkg::*;
#(
    parameter int BANK_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cs,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_dout,
    input  logic        wr_stb,
    input  logic        rd_stb,
    input  logic [4:0]  mapper,
    input  logic [26:0] base_addr,
    input  logic [15:0] size,
    output logic [26:0] mem_addr,
    output logic        mem_oe,
    output logic        mem_hit,
    output logic        scc_en
);

    lookup_ram_t       lut;
    mapper_cfg_t       cfg;
    logic [15:0]       pmask;
    logic [BANK_W-1:0] bank_q [4];
    logic [4:0]        mapper_q;

    logic [1:0]        page;
    logic              in_rom;
    logic              hit_c;
    logic [BANK_W-1:0] bank_c;
    logic [BANK_W-1:0] bank_m;
    logic [26:0]       offset;
    logic [26:0]       addr_c;
    logic              scc_win;
    logic              scc_hit;
    logic              wr_en;
    logic [1:0]        wr_idx;
    logic              wr_fire;

    assign lut = '{addr: base_addr, size: size};
    assign cfg = mapper_cfg(mapper);

    cart_page_mask u_page_mask (
        .size  (lut.size),
        .pmask (pmask)
    );

    // page 0..3 covers the 8 KB windows at 0x4000/0x6000/0x8000/0xA000
    assign page   = 2'(cpu_addr[15:13] - 3'd2);
    assign in_rom = (cpu_addr[15:14] == 2'b01) || (cpu_addr[15:14] == 2'b10);

    always_comb begin
        hit_c  = 1'b0;
        bank_c = '0;
        case (mapper)
            MAPPER_NONE: begin
                hit_c  = in_rom;
                bank_c = BANK_W'(page);
            end
            MAPPER_LINEAR: begin
                hit_c  = 1'b1;
                bank_c = BANK_W'(cpu_addr[15:13]);
            end
            MAPPER_ASCII8, MAPPER_KONAMI_SCC: begin
                hit_c  = in_rom;
                bank_c = bank_q[page];
            end
            MAPPER_KONAMI: begin
                hit_c  = in_rom;
                bank_c = (page == 2'd0) ? '0 : bank_q[page];
            end
            MAPPER_ASCII16: begin
                hit_c  = in_rom;
                bank_c = cpu_addr[15] ? bank_q[1] : bank_q[0];
            end
            default: hit_c = 1'b0;
        endcase
        if (lut.size == 16'd0) begin
            hit_c = 1'b0;
        end
    end

    always_comb begin
        if (cfg.win16k) begin
            bank_m = bank_c & BANK_W'(pmask >> 1);
            offset = 27'({bank_m, cpu_addr[13:0]});
        end else begin
            bank_m = bank_c & BANK_W'(pmask);
            offset = 27'({bank_m, cpu_addr[12:0]});
        end
    end

    assign addr_c = lut.addr + offset;

`ifdef CART_BANK_MAPPER_SCC_EN
    assign scc_win = (mapper == MAPPER_KONAMI_SCC) && (cpu_addr[15:11] == 5'b10011)
                     && (bank_q[2][5:0] == 6'h3F);
`else
    assign scc_win = 1'b0;
`endif
    assign scc_hit = scc_win & hit_c;

    always_comb begin
        wr_en  = 1'b0;
        wr_idx = 2'd0;
        case (mapper)
            MAPPER_ASCII8: begin
                wr_en  = (cpu_addr[15:13] == 3'b011);
                wr_idx = cpu_addr[12:11];
            end
            MAPPER_ASCII16: begin
                wr_en  = (cpu_addr[15:11] == 5'b01100) || (cpu_addr[15:11] == 5'b01110);
                wr_idx = {1'b0, cpu_addr[12]};
            end
            MAPPER_KONAMI: begin
                wr_en  = in_rom && (cpu_addr[15:13] != 3'b010);
                wr_idx = page;
            end
            MAPPER_KONAMI_SCC: begin
                // 2 KB register slot at offset 0x1000 of each 8 KB window
                wr_en  = in_rom && (cpu_addr[12:11] == 2'b10);
                wr_idx = page;
            end
            default: wr_en = 1'b0;
        endcase
    end

    assign wr_fire = wr_stb & cs & wr_en;

    // A mapper change outranks a same-cycle write: the registers restart clean.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mapper_q <= mapper;
            for (int i = 0; i < 4; i++) begin
                bank_q[i] <= BANK_W'(cfg.reset_banks[i]);
            end
        end else if (mapper != mapper_q) begin
            mapper_q <= mapper;
            for (int i = 0; i < 4; i++) begin
                bank_q[i] <= BANK_W'(cfg.reset_banks[i]);
            end
        end else if (wr_fire) begin
            bank_q[wr_idx] <= BANK_W'(cpu_dout);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_addr <= '0;
            mem_oe   <= 1'b0;
            mem_hit  <= 1'b0;
            scc_en   <= 1'b0;
        end else begin
            mem_oe  <= 1'b0;
            mem_hit <= 1'b0;
            scc_en  <= 1'b0;
            if (rd_stb && cs) begin
                mem_addr <= addr_c;
                mem_hit  <= hit_c;
                mem_oe   <= hit_c & ~scc_hit;
                scc_en   <= scc_hit;
            end
        end
    end

endmodule

// File: tb/tb_cart_bank_mapper.sv
// Directed, table-driven bench for cart_bank_mapper plus hand sequences for
// same-cycle rd/wr, mapper change, reset mid-read and the SCC window.
module tb_cart_bank_mapper;
    import cart_bank_mapper_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cs = 1'b0;
    logic [15:0] cpu_addr = '0;
    logic [7:0]  cpu_dout = '0;
    logic        wr_stb = 1'b0;
    logic        rd_stb = 1'b0;
    logic [4:0]  mapper = MAPPER_KONAMI;
    logic [26:0] base_addr = 27'h0100000;
    logic [15:0] size = 16'd16;
    logic [26:0] mem_addr;
    logic        mem_oe;
    logic        mem_hit;
    logic        scc_en;

    int checks = 0;
    int errors = 0;

    cart_bank_mapper #(.BANK_W(8)) dut (
        .clk       (clk),
        .reset     (rst),
        .cs        (cs),
        .cpu_addr  (cpu_addr),
        .cpu_dout  (cpu_dout),
        .wr_stb    (wr_stb),
        .rd_stb    (rd_stb),
        .mapper    (mapper),
        .base_addr (base_addr),
        .size      (size),
        .mem_addr  (mem_addr),
        .mem_oe    (mem_oe),
        .mem_hit   (mem_hit),
        .scc_en    (scc_en)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  mapper;
        logic [15:0] size;
        logic [26:0] base;
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [7:0]  data;
        logic        chk_addr;
        logic [26:0] exp_addr;
        logic        exp_oe;
        logic        exp_hit;
    } vec_t;

    vec_t vq[$];

    function automatic void add(logic [4:0] m, logic [15:0] sz, logic [26:0] b, logic r,
                                logic w, logic [15:0] a, logic [7:0] d, logic ca,
                                logic [26:0] ea, logic eo, logic eh);
        vec_t v;
        v = '{m, sz, b, r, w, a, d, ca, ea, eo, eh};
        vq.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic access(input logic [4:0] m, input logic [15:0] sz, input logic [26:0] b,
                          input logic r, input logic w, input logic [15:0] a,
                          input logic [7:0] d);
        @(negedge clk);
        mapper    = m;
        size      = sz;
        base_addr = b;
        cs        = r | w;
        rd_stb    = r;
        wr_stb    = w;
        cpu_addr  = a;
        cpu_dout  = d;
        @(posedge clk);
        #1;
        rd_stb = 1'b0;
        wr_stb = 1'b0;
        cs     = 1'b0;
    endtask

    localparam logic [26:0] B1 = 27'h0100000;
    localparam logic [26:0] B2 = 27'h2000000;

    initial begin
        add(MAPPER_KONAMI,  16, B1, 1, 0, 16'h8123, 8'h00, 1, 27'h0104123, 1, 1);
        add(MAPPER_KONAMI,  16, B1, 1, 0, 16'h4010, 8'h00, 1, 27'h0100010, 1, 1);
        add(MAPPER_KONAMI,  16, B1, 0, 1, 16'h6000, 8'h0A, 0, 27'h0,       0, 0);
        add(MAPPER_KONAMI,  16, B1, 1, 0, 16'h7FFF, 8'h00, 1, 27'h0115FFF, 1, 1);
        add(MAPPER_KONAMI,  16, B1, 0, 1, 16'hA000, 8'h13, 0, 27'h0,       0, 0);
        add(MAPPER_KONAMI,  16, B1, 1, 0, 16'hA001, 8'h00, 1, 27'h0106001, 1, 1);
        add(MAPPER_ASCII8,  16, B1, 0, 1, 16'h7000, 8'h05, 0, 27'h0,       0, 0);
        add(MAPPER_ASCII8,  16, B1, 1, 0, 16'h8010, 8'h00, 1, 27'h010A010, 1, 1);
        add(MAPPER_ASCII8,  16, B1, 0, 1, 16'h7000, 8'h25, 0, 27'h0,       0, 0);
        add(MAPPER_ASCII8,  16, B1, 1, 0, 16'h8010, 8'h00, 1, 27'h010A010, 1, 1);
        add(MAPPER_ASCII8,  16, B1, 0, 1, 16'h6800, 8'h02, 0, 27'h0,       0, 0);
        add(MAPPER_ASCII8,  16, B1, 1, 0, 16'h7FFF, 8'h00, 1, 27'h0105FFF, 1, 1);
        add(MAPPER_ASCII8,  16, B1, 1, 0, 16'h4000, 8'h00, 1, 27'h0100000, 1, 1);
        add(MAPPER_ASCII8,  16, B1, 1, 0, 16'hC000, 8'h00, 0, 27'h0,       0, 0);
        add(MAPPER_ASCII16, 16, B1, 0, 1, 16'h7000, 8'h03, 0, 27'h0,       0, 0);
        add(MAPPER_ASCII16, 16, B1, 1, 0, 16'hBFFF, 8'h00, 1, 27'h010FFFF, 1, 1);
        add(MAPPER_ASCII16, 16, B1, 1, 0, 16'hC000, 8'h00, 0, 27'h0,       0, 0);
        add(MAPPER_ASCII16, 16, B1, 1, 0, 16'h4000, 8'h00, 1, 27'h0100000, 1, 1);
        add(MAPPER_ASCII16,  4, B1, 1, 0, 16'h8000, 8'h00, 1, 27'h0104000, 1, 1);
        add(MAPPER_NONE,     4, B1, 1, 0, 16'h4000, 8'h00, 1, 27'h0100000, 1, 1);
        add(MAPPER_NONE,     4, B1, 1, 0, 16'hBFFF, 8'h00, 1, 27'h0107FFF, 1, 1);
        add(MAPPER_NONE,     4, B1, 1, 0, 16'h2000, 8'h00, 0, 27'h0,       0, 0);
        add(MAPPER_LINEAR,   4, B1, 1, 0, 16'hE005, 8'h00, 1, 27'h0106005, 1, 1);
        add(MAPPER_LINEAR,   8, B1, 1, 0, 16'hE005, 8'h00, 1, 27'h010E005, 1, 1);
        add(MAPPER_LINEAR,   0, B1, 1, 0, 16'h1000, 8'h00, 0, 27'h0,       0, 0);
        add(5'd20,          16, B1, 1, 0, 16'h4000, 8'h00, 0, 27'h0,       0, 0);
        add(MAPPER_KONAMI,   3, B2, 1, 0, 16'hA000, 8'h00, 1, 27'h2006000, 1, 1);
        add(MAPPER_KONAMI,   5, B2, 0, 1, 16'hA000, 8'h06, 0, 27'h0,       0, 0);
        add(MAPPER_KONAMI,   5, B2, 1, 0, 16'hA000, 8'h00, 1, 27'h200C000, 1, 1);
        add(MAPPER_KONAMI,   4, B2, 1, 0, 16'hA000, 8'h00, 1, 27'h2004000, 1, 1);

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_oe", 32'(mem_oe), 32'd0);
        chk("rst_hit", 32'(mem_hit), 32'd0);
        chk("rst_scc", 32'(scc_en), 32'd0);
        chk("rst_addr", 32'(mem_addr), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            access(vq[i].mapper, vq[i].size, vq[i].base, 0, 0, 16'h0, 8'h0);
            if (i > 0 && vq[i-1].exp_oe) chk($sformatf("v%0d_oe_pulse", i-1), 32'(mem_oe), 32'd0);
            access(vq[i].mapper, vq[i].size, vq[i].base, vq[i].rd, vq[i].wr,
                   vq[i].addr, vq[i].data);
            chk($sformatf("v%0d_oe", i), 32'(mem_oe), 32'(vq[i].exp_oe));
            if (vq[i].rd) begin
                chk($sformatf("v%0d_hit", i), 32'(mem_hit), 32'(vq[i].exp_hit));
                chk($sformatf("v%0d_scc", i), 32'(scc_en), 32'd0);
                if (vq[i].chk_addr) chk($sformatf("v%0d_addr", i), 32'(mem_addr), 32'(vq[i].exp_addr));
            end
        end

        // same-cycle read and write: read sees the pre-write r1
        access(MAPPER_KONAMI_SCC, 16, B1, 0, 0, 16'h0, 8'h0);
        access(MAPPER_KONAMI_SCC, 16, B1, 1, 1, 16'h7000, 8'h07);
        chk("rdwr_addr", 32'(mem_addr), 32'h0103000);
        chk("rdwr_oe", 32'(mem_oe), 32'd1);
        access(MAPPER_KONAMI_SCC, 16, B1, 1, 0, 16'h6000, 8'h00);
        chk("rdwr_next_addr", 32'(mem_addr), 32'h010E000);

        // mapper change: same-cycle access uses old r2, then r2 reloads
        access(MAPPER_ASCII8, 16, B1, 0, 0, 16'h0, 8'h0);
        access(MAPPER_ASCII8, 16, B1, 0, 1, 16'h7000, 8'h09);
        access(MAPPER_KONAMI, 16, B1, 1, 0, 16'h8000, 8'h00);
        chk("chg_old_addr", 32'(mem_addr), 32'h0112000);
        access(MAPPER_KONAMI, 16, B1, 1, 0, 16'h8000, 8'h00);
        chk("chg_reload_addr", 32'(mem_addr), 32'h0104000);

        // reset while the read result is being presented
        access(MAPPER_KONAMI, 16, B1, 1, 0, 16'h8123, 8'h00);
        chk("mid_pre_oe", 32'(mem_oe), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_oe", 32'(mem_oe), 32'd0);
        chk("mid_rst_hit", 32'(mem_hit), 32'd0);
        chk("mid_rst_addr", 32'(mem_addr), 32'd0);
        // reset held across an edge where rd_stb is high
        @(negedge clk);
        cs = 1'b1;
        rd_stb = 1'b1;
        cpu_addr = 16'h8123;
        @(posedge clk);
        #1;
        rd_stb = 1'b0;
        cs = 1'b0;
        chk("rst_rd_oe", 32'(mem_oe), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_oe", 32'(mem_oe), 32'd0);
        chk("post_rst_hit", 32'(mem_hit), 32'd0);

        // SCC register window
        access(MAPPER_KONAMI_SCC, 16, B1, 0, 0, 16'h0, 8'h0);
        access(MAPPER_KONAMI_SCC, 16, B1, 0, 1, 16'h9000, 8'h3F);
        access(MAPPER_KONAMI_SCC, 16, B1, 1, 0, 16'h9880, 8'h00);
`ifdef CART_BANK_MAPPER_SCC_EN
        chk("scc_en", 32'(scc_en), 32'd1);
        chk("scc_oe", 32'(mem_oe), 32'd0);
        chk("scc_hit", 32'(mem_hit), 32'd1);
`else
        chk("scc_en", 32'(scc_en), 32'd0);
        chk("scc_oe", 32'(mem_oe), 32'd1);
        chk("scc_addr", 32'(mem_addr), 32'h011F880);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
